// File: rtl/cmp_arbiter_pkg.sv
// rtl/cmp_arbiter_pkg.sv - shared types and constants for the two-requester compare arbiter
package cmp_arbiter_pkg;

  // Default operand width for the comparator datapath
  localparam int unsigned DATA_W_DEF = 32;

  // Width of the optional per-requester grant counters
  localparam int unsigned STATS_W = 16;

  // Arbiter FSM: accept a request, compare, hold the response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  // One-hot grant for a requester index
  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cmp_arbiter_cmp_unit.sv
// rtl/cmp_arbiter_cmp_unit.sv - combinational signed/unsigned magnitude comparator
module cmp_unit
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              uns_i,
  output logic              eq_o,
  output logic              lt_o,
  output logic              gt_o
);

  logic sign_diff;
  logic raw_lt;

  // Signed order is decided by the sign bits when they differ; with equal
  // signs the raw two's complement bit patterns order the same way as values.
  always_comb begin
    sign_diff = a_i[DATA_W-1] ^ b_i[DATA_W-1];
    raw_lt    = (a_i < b_i);
    eq_o      = (a_i == b_i);
    if (uns_i || !sign_diff) begin
      lt_o = raw_lt;
    end else begin
      lt_o = a_i[DATA_W-1];
    end
    gt_o = !eq_o && !lt_o;
  end

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - two-requester round-robin compare arbiter; optional grant counters under CMP_ARBITER_STATS_EN
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [1:0]        req_uns_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic              rsp_eq_o,
  output logic              rsp_lt_o,
  output logic              rsp_gt_o
`ifdef CMP_ARBITER_STATS_EN
  ,
  output logic [STATS_W-1:0] grant_cnt0_o,
  output logic [STATS_W-1:0] grant_cnt1_o
`endif
);

  state_e            state_q;
  logic              prio_q;       // requester favoured when both are valid
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              uns_q;
  logic              id_q;
  logic              rsp_valid_q;
  logic              eq_q;
  logic              lt_q;
  logic              gt_q;

  logic [1:0]        grant;
  logic              fire;
  logic              fire_id;
  logic              eq_c;
  logic              lt_c;
  logic              gt_c;

  // Grant selection: a lone requester wins, a tie goes to the favoured one
  always_comb begin
    grant = 2'b00;
    case (req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = id_to_onehot(prio_q);
      default: grant = 2'b00;
    endcase
  end

  // Accept only in IDLE and never while reset is held
  always_comb begin
    req_ready_o = (rst_ni && (state_q == IDLE)) ? grant : 2'b00;
    fire        = |(req_valid_i & req_ready_o);
    fire_id     = req_ready_o[1];
  end

  cmp_unit #(
    .DATA_W (DATA_W)
  ) u_cmp_unit (
    .a_i   (a_q),
    .b_i   (b_q),
    .uns_i (uns_q),
    .eq_o  (eq_c),
    .lt_o  (lt_c),
    .gt_o  (gt_c)
  );

  // Arbiter FSM: latch the winner's request, register the compare, hold until consumed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      uns_q       <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire) begin
            a_q     <= fire_id ? req1_a_i : req0_a_i;
            b_q     <= fire_id ? req1_b_i : req0_b_i;
            uns_q   <= req_uns_i[fire_id];
            id_q    <= fire_id;
            prio_q  <= ~fire_id;
            state_q <= CMP;
          end
        end
        CMP: begin
          eq_q        <= eq_c;
          lt_q        <= lt_c;
          gt_q        <= gt_c;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_eq_o    = eq_q;
  assign rsp_lt_o    = lt_q;
  assign rsp_gt_o    = gt_q;

`ifdef CMP_ARBITER_STATS_EN
  logic [STATS_W-1:0] cnt0_q;
  logic [STATS_W-1:0] cnt1_q;

  // Per-requester transfer counters, wrapping naturally at full scale
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (fire) begin
      if (fire_id) begin
        cnt1_q <= cnt1_q + 1'b1;
      end else begin
        cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;
`endif

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the operand width in bits.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req_valid_i  input  2  SHALL be the per-requester request valid (bit i = requester i).
REQ-005 req_ready_o  output  2  SHALL be the per-requester accept; a transfer occurs when valid[i] and ready[i] are both 1 at a clock edge.
REQ-006 req0_a_i, req0_b_i  input  DATA_W each  SHALL be requester 0's operands.
REQ-007 req1_a_i, req1_b_i  input  DATA_W each  SHALL be requester 1's operands.
REQ-008 req_uns_i  input  2  SHALL select the compare mode per requester: 1 = unsigned, 0 = signed two's complement.
REQ-009 rsp_valid_o  output  1  SHALL flag a valid registered result.
REQ-010 rsp_ready_i  input  1  SHALL be the consumer accept for the result.
REQ-011 rsp_id_o  output  1  SHALL give the requester index owning the result.
REQ-012 rsp_eq_o, rsp_lt_o, rsp_gt_o  output  1 each  SHALL give a==b, a<b and a>b.

Function
REQ-013 The block SHALL be an FSM with states IDLE, CMP and RESP.
REQ-014 In IDLE, the grant SHALL be computed combinationally. If one valid is set, that requester wins. If both are set, the requester not granted most recently wins.
REQ-015 req_ready_o SHALL equal the one-hot grant in IDLE and SHALL be 2'b00 in CMP and RESP.
REQ-016 On a transfer, the block SHALL latch operands, mode and id, then go IDLE->CMP.
REQ-017 The priority pointer SHALL update only on a transfer.
REQ-018 CMP SHALL last exactly one cycle: it registers eq/lt/gt and goes to RESP. Result latency is 2 cycles from the accepting edge to rsp_valid_o=1.
REQ-019 In RESP, rsp_valid_o SHALL be 1, with rsp_id/eq/lt/gt stable until rsp_ready_i=1. It then goes to IDLE; rsp_ready_i is ignored outside RESP.
REQ-020 Exactly one of eq/lt/gt SHALL be 1 whenever rsp_valid_o=1.
REQ-021 Signed mode SHALL order by the MSB sign first, then by magnitude. Unsigned mode SHALL compare the raw DATA_W bits.
REQ-022 Requesters SHALL hold valid and operands stable until accepted; the block does not guard against withdrawal.
REQ-023 Minimum issue interval SHALL be 3 cycles (IDLE, CMP, RESP with rsp_ready_i=1).

Reset
REQ-024 Reset assertion SHALL, asynchronously, force: state=IDLE, priority pointer favouring requester 0, rsp_valid_o=0, rsp_id_o=0, rsp_eq/lt/gt_o=0, operand registers=0.
REQ-025 In-flight transactions at reset SHALL be discarded with no response.
REQ-026 While rst_ni=0, req_ready_o SHALL be 2'b00.
REQ-027 The first grant after deassertion SHALL be possible at the first rising edge.

Configuration
REQ-028 With macro CMP_ARBITER_STATS_EN defined, the block SHALL add outputs grant_cnt0_o and grant_cnt1_o (16 bits each). Each counts transfers for its requester, reset to 0, and wraps 0xFFFF->0x0000.
REQ-029 Without CMP_ARBITER_STATS_EN, those ports and counters SHALL not exist and all other behaviour is identical.

Structure
REQ-030 Shared package cmp_arbiter_pkg SHALL hold the state enum (IDLE, CMP, RESP), the DATA_W default and the stats counter width.
REQ-031 Sub-module cmp_unit SHALL be purely combinational: DATA_W operands plus uns in, eq/lt/gt out. It is instantiated once inside cmp_arbiter.

Verification
REQ-032 Reset, then requester 0: a=5, b=5, signed -> rsp_valid 2 cycles after accept, id=0, eq=1, lt=0, gt=0.
REQ-033 Requester 1: a=0x80000000, b=0x7FFFFFFF, signed -> lt=1. Repeat with unsigned -> gt=1.
REQ-034 Both valid continuously for 4 transactions after reset -> grant order 0,1,0,1; rsp_id matches that order.
REQ-035 rsp_ready_i held 0 for 5 cycles in RESP -> rsp outputs stable, req_ready_o=00, no new grant; then ready=1 -> IDLE next cycle.
REQ-036 rst_ni pulsed low during CMP -> no rsp_valid afterward, pointer back to requester 0, next simultaneous request granted to 0.
REQ-037 With CMP_ARBITER_STATS_EN, 0x10001 grants to requester 0 -> grant_cnt0_o=1, grant_cnt1_o unchanged.
